// File: rtl/ram_arbiter.sv
// Two-port (IF / MEM) arbiter sequencing one access at a time into the shared RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise MEM has fixed priority.
module ram_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch port (read only)
  input  logic          if_req_valid_i,
  output logic          if_req_ready_o,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_rsp_valid_o,
  input  logic          if_rsp_ready_i,
  output logic [31:0]   if_rsp_inst_o,
  // load/store port
  input  logic          mem_req_valid_i,
  output logic          mem_req_ready_o,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  input  logic [DW-1:0] mem_wmask_i,
  output logic          mem_rsp_valid_o,
  input  logic          mem_rsp_ready_i,
  output logic [DW-1:0] mem_rdata_o,
  // shared RAM
  output logic          ram_ren_o,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_raddr_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [DW-1:0] ram_wmask_o,
  input  logic [DW-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q;
  logic          lg_mem_q;      // last serviced port: 1 = MEM, 0 = IF
  logic          own_mem_q;     // port that owns the in-flight transaction
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] wmask_q;
  logic          if_valid_q;
  logic          mem_valid_q;
  logic [31:0]   inst_q;
  logic [DW-1:0] rdata_q;

  logic tie_mem;
  logic grant_mem;
  logic idle;
  logic do_rd;
  logic do_wr;

`ifdef RAM_ARB_RR_EN
  assign tie_mem = ~lg_mem_q;
`else
  logic unused_lg;
  assign tie_mem   = 1'b1;
  assign unused_lg = lg_mem_q;
`endif

  // Ready is purely a function of state, last grant and the two request valids.
  assign idle            = (state_q == IDLE) && !rst;
  assign grant_mem       = mem_req_valid_i & (~if_req_valid_i | tie_mem);
  assign mem_req_ready_o = idle & grant_mem;
  assign if_req_ready_o  = idle & if_req_valid_i & ~grant_mem;

  assign do_rd = (state_q == ACCESS) & ~we_q;
  assign do_wr = (state_q == ACCESS) & we_q;

  // Enables are gated with reset so an interrupted ACCESS never commits.
  assign ram_ren_o   = do_rd & ~rst;
  assign ram_wen_o   = do_wr & ~rst;
  assign ram_raddr_o = do_rd ? addr_q  : '0;
  assign ram_waddr_o = do_wr ? addr_q  : '0;
  assign ram_wdata_o = do_wr ? wdata_q : '0;
  assign ram_wmask_o = do_wr ? wmask_q : '0;

  assign if_rsp_valid_o  = if_valid_q;
  assign if_rsp_inst_o   = inst_q;
  assign mem_rsp_valid_o = mem_valid_q;
  assign mem_rdata_o     = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lg_mem_q    <= 1'b0;
      own_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      inst_q      <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req_ready_o) begin
            own_mem_q <= 1'b1;
            we_q      <= mem_we_i;
            addr_q    <= mem_addr_i;
            wdata_q   <= mem_wdata_i & mem_wmask_i;
            wmask_q   <= mem_wmask_i;
            state_q   <= ACCESS;
          end else if (if_req_ready_o) begin
            own_mem_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= if_addr_i;
            wdata_q   <= '0;
            wmask_q   <= '0;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          lg_mem_q <= own_mem_q;
          if (own_mem_q) begin
            mem_valid_q <= 1'b1;
            rdata_q     <= we_q ? '0 : ram_rdata_i;
          end else begin
            if_valid_q <= 1'b1;
            inst_q     <= ram_rdata_i[31:0];
          end
          state_q <= RESP;
        end
        RESP: begin
          if ((mem_valid_q && mem_rsp_ready_i) || (if_valid_q && if_rsp_ready_i)) begin
            mem_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
